// File: rtl/soft_rst_seq_if.sv
// Control/status bundle between the soft reset sequencer and its environment.
// master drives the requests and lock status; slave (the sequencer) drives the resets and status.
interface soft_rst_seq_if #(
   parameter int RTW = 2
);
   logic           sw_rst_req;
   logic           sw_rx_rst_req;
   logic           rx_lock;
   logic           soft_pcs_rst_n;
   logic           soft_tx_rst_n;
   logic           soft_rx_rst_n;
   logic           busy;
   logic           link_up;
   logic           fail;
   logic [RTW-1:0] retry_cnt;
   logic [2:0]     dbg_state;

   modport master (
      output sw_rst_req, sw_rx_rst_req, rx_lock,
      input  soft_pcs_rst_n, soft_tx_rst_n, soft_rx_rst_n,
      input  busy, link_up, fail, retry_cnt, dbg_state
   );

   modport slave (
      input  sw_rst_req, sw_rx_rst_req, rx_lock,
      output soft_pcs_rst_n, soft_tx_rst_n, soft_rx_rst_n,
      output busy, link_up, fail, retry_cnt, dbg_state
   );
endinterface

// File: rtl/soft_rst_seq.sv
// Soft PCS/TX/RX reset sequencer in the cfg clock domain: PCS, then TX, then RX, then wait
// for RX lock, retrying RX-only reset on lock timeout or lock loss.
module soft_rst_seq #(
   parameter int CNT_W        = 16,
   parameter int PCS_HOLD_CYC = 16,
   parameter int TX_DLY_CYC   = 8,
   parameter int RX_DLY_CYC   = 8,
   parameter int LOCK_TMO_CYC = 1024,
   parameter int MAX_RETRY    = 3
) (
   input  logic                i_cfg_clk,
   input  logic                i_cfg_rst_n,
   soft_rst_seq_if.slave       bus
);
   localparam int RTW = $clog2(MAX_RETRY + 1);

   if (PCS_HOLD_CYC < 1 || PCS_HOLD_CYC >= (2 ** CNT_W) ||
       TX_DLY_CYC   < 1 || TX_DLY_CYC   >= (2 ** CNT_W) ||
       RX_DLY_CYC   < 1 || RX_DLY_CYC   >= (2 ** CNT_W) ||
       LOCK_TMO_CYC < 1 || LOCK_TMO_CYC >= (2 ** CNT_W) ||
       MAX_RETRY    < 1) begin : g_bad_param
      $error("soft_rst_seq: cycle parameter out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] PCS_END   = CNT_W'(PCS_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TX_END    = CNT_W'(TX_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] RX_END    = CNT_W'(RX_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_END  = CNT_W'(LOCK_TMO_CYC - 1);
   localparam logic [RTW-1:0]   RETRY_MAX = RTW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_PCS  = 3'd0,
      S_TX   = 3'd1,
      S_RX   = 3'd2,
      S_LOCK = 3'd3,
      S_UP   = 3'd4,
      S_FAIL = 3'd5
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RTW-1:0]   retry_q;
   logic             pcs_rst_n_q;
   logic             tx_rst_n_q;
   logic             rx_rst_n_q;
   logic             busy_q;
   logic             link_up_q;
   logic             fail_q;

   // Every branch assigns the full output set for its target state so the
   // registered outputs always match state_q on the same edge.
   always_ff @(posedge i_cfg_clk) begin
      if (!i_cfg_rst_n || bus.sw_rst_req) begin
         state_q     <= S_PCS;
         cnt_q       <= '0;
         retry_q     <= '0;
         pcs_rst_n_q <= 1'b0;
         tx_rst_n_q  <= 1'b0;
         rx_rst_n_q  <= 1'b0;
         busy_q      <= 1'b1;
         link_up_q   <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         case (state_q)
            S_PCS: begin
               if (cnt_q == PCS_END) begin
                  state_q     <= S_TX;
                  cnt_q       <= '0;
                  pcs_rst_n_q <= 1'b1;
               end
            end
            S_TX: begin
               if (cnt_q == TX_END) begin
                  state_q    <= S_RX;
                  cnt_q      <= '0;
                  tx_rst_n_q <= 1'b1;
               end
            end
            S_RX: begin
               if (cnt_q == RX_END) begin
                  state_q    <= S_LOCK;
                  cnt_q      <= '0;
                  rx_rst_n_q <= 1'b1;
               end
            end
            S_LOCK: begin
               if (bus.sw_rx_rst_req) begin
                  state_q    <= S_RX;
                  cnt_q      <= '0;
                  retry_q    <= '0;
                  rx_rst_n_q <= 1'b0;
               end else if (bus.rx_lock) begin
                  state_q   <= S_UP;
                  cnt_q     <= '0;
                  busy_q    <= 1'b0;
                  link_up_q <= 1'b1;
               end else if (cnt_q == LOCK_END) begin
                  cnt_q      <= '0;
                  rx_rst_n_q <= 1'b0;
                  if (retry_q == RETRY_MAX) begin
                     state_q <= S_FAIL;
                     busy_q  <= 1'b0;
                     fail_q  <= 1'b1;
                  end else begin
                     state_q <= S_RX;
                     retry_q <= retry_q + 1'b1;
                  end
               end
            end
            S_UP: begin
               cnt_q <= '0;
               if (bus.sw_rx_rst_req || !bus.rx_lock) begin
                  state_q    <= S_RX;
                  retry_q    <= '0;
                  rx_rst_n_q <= 1'b0;
                  busy_q     <= 1'b1;
                  link_up_q  <= 1'b0;
               end
            end
            S_FAIL: begin
               cnt_q <= '0;
               if (bus.sw_rx_rst_req) begin
                  state_q <= S_RX;
                  retry_q <= '0;
                  busy_q  <= 1'b1;
                  fail_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_PCS;
               cnt_q       <= '0;
               retry_q     <= '0;
               pcs_rst_n_q <= 1'b0;
               tx_rst_n_q  <= 1'b0;
               rx_rst_n_q  <= 1'b0;
               busy_q      <= 1'b1;
               link_up_q   <= 1'b0;
               fail_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.soft_pcs_rst_n = pcs_rst_n_q;
   assign bus.soft_tx_rst_n  = tx_rst_n_q;
   assign bus.soft_rx_rst_n  = rx_rst_n_q;
   assign bus.busy           = busy_q;
   assign bus.link_up        = link_up_q;
   assign bus.fail           = fail_q;
   assign bus.retry_cnt      = retry_q;
   assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_soft_rst_seq.sv
// Directed bench for soft_rst_seq: timeline checks against a fixed edge schedule plus a
// per-cycle reset ordering check.
module tb_soft_rst_seq;
   localparam int RTW = 2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   t;
   bit   started;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   soft_rst_seq_if #(.RTW(RTW)) bus ();

   soft_rst_seq #(
      .CNT_W(16), .PCS_HOLD_CYC(16), .TX_DLY_CYC(8), .RX_DLY_CYC(8),
      .LOCK_TMO_CYC(64), .MAX_RETRY(2)
   ) dut (
      .i_cfg_clk  (clk),
      .i_cfg_rst_n(rst_n),
      .bus        (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // {pcs, tx, rx, busy, link_up, fail, retry[1:0]}
   function automatic logic [7:0] ev(input bit pcs, input bit tx, input bit rx, input bit busy,
                                      input bit up, input bit fl, input int retry);
      return {pcs, tx, rx, busy, up, fl, 2'(retry)};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {bus.soft_pcs_rst_n, bus.soft_tx_rst_n, bus.soft_rx_rst_n, bus.busy,
              bus.link_up, bus.fail, bus.retry_cnt};
   endfunction

   // driver tasks: t counts edges since the reset edge; we always sit 1 time unit after an edge
   task automatic adv_to(input int n);
      while (t < n) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   task automatic check_at(input string tag, input int n, input logic [7:0] e);
      logic [7:0] obs;
      logic [7:0] want;
      string      tg;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      adv_to(n);
      obs  = obs_vec();
      want = exp_q.pop_front();
      tg   = tag_q.pop_front();
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s @edge %0d: obs=%b exp=%b", tg, t, obs, want);
      end
   endtask

   // reset ordering must hold every cycle, including across restarts
   always @(negedge clk) begin
      if (started) begin
         total++;
         assert (!((bus.soft_pcs_rst_n !== 1'b1 && (bus.soft_tx_rst_n !== 1'b0 || bus.soft_rx_rst_n !== 1'b0)) ||
                   (bus.soft_tx_rst_n !== 1'b1 && bus.soft_rx_rst_n !== 1'b0))) else begin
            bad++;
            $error("FAIL order @edge %0d: obs pcs/tx/rx=%b%b%b exp=ordered release", t,
                   bus.soft_pcs_rst_n, bus.soft_tx_rst_n, bus.soft_rx_rst_n);
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      t     = 0;
      started = 1'b0;
      rst_n = 1'b0;
      bus.sw_rst_req    = 1'b0;
      bus.sw_rx_rst_req = 1'b0;
      bus.rx_lock       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      t = 0;
      started = 1'b1;
      check_at("reset", 0, ev(0, 0, 0, 1, 0, 0, 0));
      rst_n = 1'b1;

      // straight bring-up with lock present
      bus.rx_lock = 1'b1;
      check_at("pcs_hold", 15, ev(0, 0, 0, 1, 0, 0, 0));
      check_at("pcs_rel",  16, ev(1, 0, 0, 1, 0, 0, 0));
      check_at("tx_hold",  23, ev(1, 0, 0, 1, 0, 0, 0));
      check_at("tx_rel",   24, ev(1, 1, 0, 1, 0, 0, 0));
      check_at("rx_hold",  31, ev(1, 1, 0, 1, 0, 0, 0));
      check_at("rx_rel",   32, ev(1, 1, 1, 1, 0, 0, 0));
      check_at("link_up",  33, ev(1, 1, 1, 0, 1, 0, 0));

      // lock loss in S_UP, then relock
      adv_to(40);
      bus.rx_lock = 1'b0;
      check_at("loss",      41, ev(1, 1, 0, 1, 0, 0, 0));
      check_at("loss_hold", 48, ev(1, 1, 0, 1, 0, 0, 0));
      check_at("loss_rel",  49, ev(1, 1, 1, 1, 0, 0, 0));
      bus.rx_lock = 1'b1;
      check_at("relock",    50, ev(1, 1, 1, 0, 1, 0, 0));

      // drop lock again, then full restart from S_LOCK
      adv_to(60);
      bus.rx_lock = 1'b0;
      check_at("loss2",     61, ev(1, 1, 0, 1, 0, 0, 0));
      check_at("lock_wait", 70, ev(1, 1, 1, 1, 0, 0, 0));
      bus.sw_rst_req = 1'b1;
      check_at("sw_rst",    71, ev(0, 0, 0, 1, 0, 0, 0));
      bus.sw_rst_req = 1'b0;
      check_at("sw_pcs_hold", 86, ev(0, 0, 0, 1, 0, 0, 0));
      check_at("sw_pcs_rel",  87, ev(1, 0, 0, 1, 0, 0, 0));

      // no lock ever: two retries then fail
      check_at("tx_rel2",  95,  ev(1, 1, 0, 1, 0, 0, 0));
      check_at("lock_in",  103, ev(1, 1, 1, 1, 0, 0, 0));
      check_at("tmo_edge", 166, ev(1, 1, 1, 1, 0, 0, 0));
      check_at("retry1",   167, ev(1, 1, 0, 1, 0, 0, 1));
      check_at("retry1_r", 175, ev(1, 1, 1, 1, 0, 0, 1));
      check_at("retry2",   239, ev(1, 1, 0, 1, 0, 0, 2));
      check_at("retry2_h", 246, ev(1, 1, 0, 1, 0, 0, 2));
      check_at("retry2_r", 247, ev(1, 1, 1, 1, 0, 0, 2));
      check_at("pre_fail", 310, ev(1, 1, 1, 1, 0, 0, 2));
      check_at("fail",     311, ev(1, 1, 0, 0, 0, 1, 2));
      check_at("fail_sty", 314, ev(1, 1, 0, 0, 0, 1, 2));

      // both requests together in S_FAIL: full restart wins
      adv_to(315);
      bus.sw_rst_req    = 1'b1;
      bus.sw_rx_rst_req = 1'b1;
      check_at("both_req", 316, ev(0, 0, 0, 1, 0, 0, 0));
      bus.sw_rst_req    = 1'b0;
      bus.sw_rx_rst_req = 1'b0;

      // RX-only request while in S_TX is ignored
      adv_to(335);
      bus.sw_rx_rst_req = 1'b1;
      check_at("rxreq_tx", 336, ev(1, 0, 0, 1, 0, 0, 0));
      bus.sw_rx_rst_req = 1'b0;
      check_at("tx_rel3",  340, ev(1, 1, 0, 1, 0, 0, 0));
      check_at("rx_rel3",  348, ev(1, 1, 1, 1, 0, 0, 0));

      // lock arrives on the timeout edge: lock wins
      adv_to(411);
      bus.rx_lock = 1'b1;
      check_at("lock_vs_tmo", 412, ev(1, 1, 1, 0, 1, 0, 0));

      // RX-only request from S_UP
      adv_to(415);
      bus.sw_rx_rst_req = 1'b1;
      check_at("rxreq_up", 416, ev(1, 1, 0, 1, 0, 0, 0));
      bus.sw_rx_rst_req = 1'b0;

      // hard reset mid S_RX
      adv_to(420);
      rst_n = 1'b0;
      check_at("mid_rst", 421, ev(0, 0, 0, 1, 0, 0, 0));
      rst_n = 1'b1;
      check_at("mid_pcs_hold", 436, ev(0, 0, 0, 1, 0, 0, 0));
      check_at("mid_pcs_rel",  437, ev(1, 0, 0, 1, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
